// File: rtl/bus_grant_ctrl.sv
// Four-client bus grant controller: ranked arbitration in IDLE, a held one-hot
// grant in BUSY, a one-cycle turnaround between owners and a hold-time limit.
module bus_grant_ctrl #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] client_req,
  input  logic [3:0] client_done,
  input  logic [1:0] first_priority_channel_addr,
  input  logic [1:0] second_priority_channel_addr,
  input  logic [1:0] third_priority_channel_addr,
  input  logic [1:0] fourth_priority_channel_addr,
  output logic [3:0] client_grant,
  output logic [1:0] bus_owner,
  output logic       bus_busy,
  output logic       grant_timeout
);

  localparam int CNT_W = $clog2(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [CNT_W-1:0] hold_cnt;
  logic             mask_valid;
  logic [1:0]       mask_idx;

  logic [1:0] rank [4];
  logic [3:0] mask_vec;
  logic [3:0] eligible;
  logic       has_winner;
  logic       ranked_hit;
  logic [1:0] winner;
  logic       owner_release;

  assign rank[0] = first_priority_channel_addr;
  assign rank[1] = second_priority_channel_addr;
  assign rank[2] = third_priority_channel_addr;
  assign rank[3] = fourth_priority_channel_addr;

  // done and abandon are both normal releases and take precedence over timeout.
  assign owner_release = client_done[bus_owner] || !client_req[bus_owner];

  // NOTE: every variable driven here gets a default first, so no latch is inferred.
  always_comb begin
    mask_vec   = mask_valid ? (4'b0001 << mask_idx) : 4'b0000;
    eligible   = client_req & ~mask_vec;
    ranked_hit = 1'b0;
    winner     = 2'd0;
    // A timed-out client that is the only requester is not starved.
    if (eligible == 4'b0000) eligible = client_req;
    has_winner = |eligible;
    for (int r = 0; r < 4; r++) begin
      if (!ranked_hit && eligible[rank[r]]) begin
        winner     = rank[r];
        ranked_hit = 1'b1;
      end
    end
    // Duplicate or stale ranks: fall back to the lowest-index eligible client.
    if (!ranked_hit) begin
      for (int i = 3; i >= 0; i--) begin
        if (eligible[i]) winner = 2'(i);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      hold_cnt      <= '0;
      mask_valid    <= 1'b0;
      mask_idx      <= 2'd0;
      client_grant  <= 4'b0000;
      bus_owner     <= 2'd0;
      bus_busy      <= 1'b0;
      grant_timeout <= 1'b0;
    end else begin
      grant_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (has_winner) begin
            state        <= BUSY;
            client_grant <= 4'b0001 << winner;
            bus_owner    <= winner;
            bus_busy     <= 1'b1;
            hold_cnt     <= '0;
            mask_valid   <= 1'b0;
          end
        end
        BUSY: begin
          if (owner_release) begin
            state        <= IDLE;
            client_grant <= 4'b0000;
            bus_busy     <= 1'b0;
          end else if (hold_cnt == HOLD_LAST) begin
            state         <= IDLE;
            client_grant  <= 4'b0000;
            bus_busy      <= 1'b0;
            grant_timeout <= 1'b1;
            mask_valid    <= 1'b1;
            mask_idx      <= bus_owner;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_grant_ctrl.sv
// Directed bench for bus_grant_ctrl: each step pushes the expected outputs to a
// scoreboard queue, clocks once and compares what the DUT registered.
module tb_bus_grant_ctrl;

  localparam int MAX_HOLD = 16;

  logic       clk;
  logic       reset;
  logic [3:0] client_req;
  logic [3:0] client_done;
  logic [1:0] first_addr, second_addr, third_addr, fourth_addr;
  logic [3:0] client_grant;
  logic [1:0] bus_owner;
  logic       bus_busy;
  logic       grant_timeout;

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] owner;
    logic       busy;
    logic       timeout;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  bus_grant_ctrl #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk                          (clk),
    .reset                        (reset),
    .client_req                   (client_req),
    .client_done                  (client_done),
    .first_priority_channel_addr  (first_addr),
    .second_priority_channel_addr (second_addr),
    .third_priority_channel_addr  (third_addr),
    .fourth_priority_channel_addr (fourth_addr),
    .client_grant                 (client_grant),
    .bus_owner                    (bus_owner),
    .bus_busy                     (bus_busy),
    .grant_timeout                (grant_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_outputs(input string tag, input exp_t e);
    check({tag, ".grant"},   {4'b0, client_grant},  {4'b0, e.grant});
    check({tag, ".owner"},   {6'b0, bus_owner},     {6'b0, e.owner});
    check({tag, ".busy"},    {7'b0, bus_busy},      {7'b0, e.busy});
    check({tag, ".timeout"}, {7'b0, grant_timeout}, {7'b0, e.timeout});
  endtask

  task automatic set_ranks(input logic [1:0] a, b, c, d);
    first_addr = a; second_addr = b; third_addr = c; fourth_addr = d;
  endtask

  // Drive one cycle of inputs, expect the given registered outputs after the edge.
  task automatic cycle(input string tag, input logic [3:0] req, input logic [3:0] done,
                       input logic [3:0] g, input logic [1:0] o, input logic to);
    exp_t e;
    client_req  = req;
    client_done = done;
    sb_q.push_back('{grant: g, owner: o, busy: (g != 4'b0000), timeout: to});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
    end else begin
      e = sb_q.pop_front();
      compare_outputs(tag, e);
    end
  endtask

  initial begin
    reset       = 1'b1;
    client_req  = 4'b0000;
    client_done = 4'b0000;
    set_ranks(2'd2, 2'd0, 2'd3, 2'd1);
    @(posedge clk);
    #1;
    compare_outputs("reset", '{grant: 4'b0, owner: 2'd0, busy: 1'b0, timeout: 1'b0});
    reset = 1'b0;

    // Ranked grant, 3-cycle hold ended by done, then next client after turnaround.
    cycle("rank_grant",  4'b0101, 4'b0000, 4'b0100, 2'd2, 1'b0);
    cycle("hold2",       4'b0101, 4'b0000, 4'b0100, 2'd2, 1'b0);
    cycle("hold3",       4'b0101, 4'b0000, 4'b0100, 2'd2, 1'b0);
    cycle("done_drop",   4'b0101, 4'b0100, 4'b0000, 2'd2, 1'b0);
    cycle("next_owner",  4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b0);
    cycle("abandon",     4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
    cycle("idle_done",   4'b0000, 4'b1111, 4'b0000, 2'd0, 1'b0);

    // Timeout after exactly MAX_HOLD cycles; masked owner skipped next time.
    cycle("to_grant",    4'b0101, 4'b0000, 4'b0100, 2'd2, 1'b0);
    for (int i = 1; i < MAX_HOLD; i++)
      cycle("to_hold",   4'b0101, 4'b0000, 4'b0100, 2'd2, 1'b0);
    cycle("to_pulse",    4'b0101, 4'b0000, 4'b0000, 2'd2, 1'b1);
    cycle("masked",      4'b0101, 4'b0000, 4'b0001, 2'd0, 1'b0);
    cycle("masked_rel",  4'b0101, 4'b0001, 4'b0000, 2'd0, 1'b0);
    cycle("unmasked",    4'b0101, 4'b0000, 4'b0100, 2'd2, 1'b0);
    cycle("unmask_rel",  4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0);

    // Sole requester after its own timeout: the mask is ignored.
    cycle("solo_grant",  4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0);
    for (int i = 1; i < MAX_HOLD; i++)
      cycle("solo_hold", 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0);
    cycle("solo_to",     4'b0100, 4'b0000, 4'b0000, 2'd2, 1'b1);
    cycle("solo_again",  4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0);
    cycle("solo_rel",    4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0);

    // Duplicate ranks fall back to the lowest-index eligible client.
    set_ranks(2'd3, 2'd3, 2'd3, 2'd3);
    cycle("fallback0",   4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b0);
    cycle("fb0_rel",     4'b0010, 4'b0001, 4'b0000, 2'd0, 1'b0);
    cycle("fallback1",   4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0);
    cycle("fb1_rel",     4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0);

    // done coincides with the hold limit: no timeout, no mask. Non-owner done
    // and rank changes while BUSY have no effect.
    set_ranks(2'd2, 2'd0, 2'd3, 2'd1);
    cycle("co_grant",    4'b0101, 4'b0000, 4'b0100, 2'd2, 1'b0);
    for (int i = 1; i < MAX_HOLD; i++) begin
      if (i == 8) set_ranks(2'd0, 2'd2, 2'd3, 2'd1);
      if (i == 9) set_ranks(2'd2, 2'd0, 2'd3, 2'd1);
      cycle("co_hold",   4'b0101, (i == 5) ? 4'b0001 : 4'b0000, 4'b0100, 2'd2, 1'b0);
    end
    cycle("co_done",     4'b0101, 4'b0100, 4'b0000, 2'd2, 1'b0);
    cycle("co_regrant",  4'b0101, 4'b0000, 4'b0100, 2'd2, 1'b0);
    cycle("co_rel",      4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0);

    // Reset mid-BUSY clears outputs without waiting for a clock edge.
    cycle("pre_reset",   4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b0);
    #2;
    client_req = 4'b0000;
    reset      = 1'b1;
    #1;
    compare_outputs("async_reset", '{grant: 4'b0, owner: 2'd0, busy: 1'b0, timeout: 1'b0});
    reset = 1'b0;
    cycle("post_rst0",   4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
    cycle("post_rst1",   4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
    cycle("post_grant",  4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_grant_ctrl.md
# bus_grant_ctrl

Four-client bus grant controller that sits downstream of the priority sorter. It consumes the sorter's four ranked channel addresses and the clients' request and done lines, and issues a single one-hot bus grant. Each grant is held until the owner finishes or a hold-time limit expires. One idle turnaround cycle separates successive owners, and a timed-out owner is barred from the immediately following arbitration.

## Interface
- MAX_HOLD, 16: maximum number of cycles a grant stays asserted; legal range 2..255.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- client_req  in  4  bit i is high while client i+1 wants the bus (level); must stay high until granted.
- client_done  in  4  bit i is a one-cycle pulse from client i+1 ending its transfer; ignored unless client i+1 owns the bus.
- first_priority_channel_addr  in  2  index of the highest-ranked client.
- second_priority_channel_addr  in  2  index of the 2nd-ranked client.
- third_priority_channel_addr  in  2  index of the 3rd-ranked client.
- fourth_priority_channel_addr  in  2  index of the lowest-ranked client.
- client_grant  out  4  one-hot grant, or all zero; registered.
- bus_owner  out  2  index of the current or most recent owner; registered.
- bus_busy  out  1  high exactly when client_grant is nonzero.
- grant_timeout  out  1  one-cycle pulse when a grant is revoked by the hold limit.

## Operation
- Reset values:
  - client_grant=0, bus_owner=0, bus_busy=0, grant_timeout=0.
  - FSM=IDLE, hold_cnt=0, timeout mask cleared.
- FSM has two states: IDLE and BUSY.
- IDLE (grant=0): arbitrate every cycle.
  - Eligible set = client_req with the masked client removed. If removing it leaves the set empty, the mask is ignored.
  - Winner = the first eligible client in the order first, second, third, fourth addr.
  - If no ranked address hits an eligible client (duplicate or stale addresses), the winner is the lowest-index eligible client.
  - With a winner: go to BUSY, load client_grant=1<<winner, bus_owner=winner, hold_cnt=0, and clear the mask.
  - With no eligible requester: stay in IDLE.
- BUSY: grant is held and hold_cnt increments each cycle. The FSM leaves BUSY at the edge where any of the following is sampled:
  - client_done[bus_owner]=1: normal release.
  - client_req[bus_owner]=0: abandon, treated as a normal release.
  - hold_cnt==MAX_HOLD-1 with neither of the above: timeout. grant_timeout=1 for one cycle, and the mask is set to bus_owner.
- On exit from BUSY: go to IDLE and clear client_grant. bus_owner keeps its value.
- Precedence: done or abandon beats timeout in the same cycle, so no timeout pulse and no mask.
- Priority addresses are sampled only in IDLE. Changes during BUSY never preempt the owner.
- done pulses from non-owners, and done pulses seen in IDLE, are ignored.
- hold_cnt width is clog2(MAX_HOLD); it never wraps because the FSM exits at MAX_HOLD-1.

## Timing
- Request to grant: client_req sampled high at IDLE edge k → client_grant visible after edge k (1-cycle latency).
- Grant duration:
  - Minimum is 1 cycle (done sampled at the first BUSY edge).
  - Maximum is exactly MAX_HOLD cycles.
- Turnaround: at least one all-zero grant cycle between consecutive owners. Back-to-back throughput is 1 grant per (hold + 1) cycles.
- grant_timeout is high during the first IDLE cycle after a timeout, aligned with client_grant returning to 0.
- Reset mid-BUSY: outputs clear asynchronously. After reset release, the first grant requires a fresh IDLE arbitration edge.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Ranks first=2, second=0, third=3, fourth=1; client_req=4'b0101 → client_grant=4'b0100 and bus_owner=2 one cycle later; bus_busy=1.
- Owner 2 pulses done on its 3rd grant cycle → grant is 0 for 1 cycle, then client_grant=4'b0001 and bus_owner=0.
- MAX_HOLD=16, client 3 held requesting and never done, client 1 also requesting → 4'b0100 high exactly 16 cycles, grant_timeout pulses once, next grant is 4'b0001 despite client 3 ranking higher; client 3 is then granted after client 1 releases.
- All four rank addresses = 2'b11, client_req=4'b0011 → fallback client_grant=4'b0001.
- done and the hold limit coincide on cycle 16 → grant drops, grant_timeout stays 0, and the same client may win the next arbitration.
- reset asserted mid-BUSY → client_grant, bus_busy and bus_owner go to 0 immediately. After release with client_req=0, no grant appears; client_req=4'b1000 then produces 4'b1000 after 1 cycle.
